// File: rtl/regfile_writeback_arbiter.sv
// Write-port producer for the register file: merges ALU and load results into one
// registered write per cycle and tracks destination registers with writes in flight.
module regfile_writeback_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LD_DEPTH = 4
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              wen,
  output logic [AW-1:0]     wsel,
  output logic [XLEN-1:0]   wdata,
  output logic [2**AW-1:0]  busy,
  output logic              ld_full
);

  localparam int PW   = $clog2(LD_DEPTH);
  localparam int NREG = 2**AW;

  logic              hold_valid;
  logic [AW-1:0]     hold_rd;
  logic [XLEN-1:0]   hold_data;

  logic [AW-1:0]     fifo_rd   [LD_DEPTH];
  logic [XLEN-1:0]   fifo_data [LD_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count;
  logic              fifo_empty;

  logic              alu_wins;
  logic              load_wins;
  logic              alu_push;
  logic              ld_push;
  logic [AW-1:0]     win_rd;
  logic [XLEN-1:0]   win_data;
  logic [NREG-1:0]   busy_next;

  assign fifo_empty = (count == '0);
  assign ld_full    = (count == (PW+1)'(LD_DEPTH));

  // A full load FIFO pre-empts the holding register so loads cannot be starved.
  assign load_wins = !fifo_empty && (ld_full || !hold_valid);
  assign alu_wins  = hold_valid && !ld_full;

  assign alu_ready = !hold_valid || alu_wins;
  assign ld_ready  = !ld_full || load_wins;
  assign alu_push  = alu_valid && alu_ready;
  assign ld_push   = ld_valid && ld_ready;

  always_comb begin
    win_rd   = hold_rd;
    win_data = hold_data;
    if (load_wins) begin
      win_rd   = fifo_rd[rptr];
      win_data = fifo_data[rptr];
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else if (alu_push) begin
      hold_valid <= 1'b1;
      hold_rd    <= alu_rd;
      hold_data  <= alu_data;
    end else if (alu_wins) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (ld_push) begin
      fifo_rd[wptr]   <= ld_rd;
      fifo_data[wptr] <= ld_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (ld_push) wptr <= wptr + PW'(1);
      if (load_wins) rptr <= rptr + PW'(1);
      case ({ld_push, load_wins})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wen   <= 1'b0;
      wsel  <= '0;
      wdata <= '0;
    end else if (alu_wins || load_wins) begin
      wen   <= (win_rd != '0);
      wsel  <= win_rd;
      wdata <= win_data;
    end else begin
      wen   <= 1'b0;
    end
  end

  // A new issue to the same register outranks the commit clearing it.
  always_comb begin
    busy_next = busy;
    if (wen) busy_next[wsel] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: table of single-cycle vectors plus
// hand-written sequences for FIFO wrap/priority and mid-stream reset.
module tb_regfile_writeback_arbiter;

  logic        wclk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic [31:0] busy;
  logic        ld_full;

  int checks = 0;
  int errors = 0;

  logic        log_en = 1'b0;
  logic [36:0] wr_log[$];

  regfile_writeback_arbiter #(.XLEN(32), .AW(5), .LD_DEPTH(4)) dut (
    .wclk(wclk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wen(wen), .wsel(wsel), .wdata(wdata), .busy(busy), .ld_full(ld_full)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (log_en && wen) wr_log.push_back({wsel, wdata});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldd;
    logic        iv;
    logic [4:0]  ird;
    logic        e_ar;
    logic        e_lr;
    logic        e_wen;
    logic        chk_w;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mkv(logic av, logic [4:0] ard, logic [31:0] ad,
                               logic lv, logic [4:0] lrd, logic [31:0] ldd,
                               logic iv, logic [4:0] ird,
                               logic ewen, logic chk, logic [4:0] esel,
                               logic [31:0] edata, logic [31:0] ebusy);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ldd = ldd;
    v.iv = iv; v.ird = ird;
    v.e_ar = 1'b1; v.e_lr = 1'b1;
    v.e_wen = ewen; v.chk_w = chk; v.e_wsel = esel; v.e_wdata = edata;
    v.e_busy = ebusy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    ld_valid  = v.lv; ld_rd  = v.lrd; ld_data  = v.ldd;
    iss_valid = v.iv; iss_rd = v.ird;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  function automatic logic [36:0] alu_item(int n);
    return {5'(8 + n), 32'hA000_0000 + 32'(n)};
  endfunction

  function automatic logic [36:0] ld_item(int n);
    return {5'(20 + n), 32'hB000_0000 + 32'(n)};
  endfunction

  initial begin
    int a_idx;
    int l_idx;
    logic acc_a;
    logic acc_l;
    logic saw_full;
    logic saw_stall;
    logic [36:0] exp_q[$];

    // idle: av,ard,ad, lv,lrd,ld, iv,ird, wen,chk,wsel,wdata, busy
    tbl[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 5, 32'hDEADBEEF, 0);
    tbl[2]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 1, 5, 32'hDEADBEEF, 0);
    tbl[3]  = mkv(1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    tbl[4]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 3, 32'h11, 0);
    tbl[5]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 4, 32'h22, 0);
    tbl[6]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 1, 4, 32'h22, 0);
    tbl[7]  = mkv(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0,   0, 1, 4, 32'h22, 0);
    tbl[8]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[10] = mkv(0, 0, 0,            0, 0, 0, 1, 7,   0, 0, 0, 0, 32'h80);
    tbl[11] = mkv(0, 0, 0,            0, 0, 0, 1, 0,   0, 0, 0, 0, 32'h80);
    tbl[12] = mkv(1, 7, 32'h77,       0, 0, 0, 0, 0,   0, 0, 0, 0, 32'h80);
    tbl[13] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 7, 32'h77, 32'h80);
    tbl[14] = mkv(0, 0, 0,            0, 0, 0, 1, 7,   0, 1, 7, 32'h77, 32'h80);
    tbl[15] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 1, 7, 32'h77, 32'h80);
    tbl[16] = mkv(1, 7, 32'h78,       0, 0, 0, 0, 0,   0, 1, 7, 32'h77, 32'h80);
    tbl[17] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 7, 32'h78, 32'h80);
    tbl[18] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 1, 7, 32'h78, 0);
    tbl[19] = mkv(0, 0, 0,            1, 12, 32'h1234, 1, 31, 0, 1, 7, 32'h78, 32'h8000_0000);
    tbl[20] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 12, 32'h1234, 32'h8000_0000);
    tbl[21] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 1, 12, 32'h1234, 32'h8000_0000);
    tbl[22] = mkv(0, 0, 0,            1, 31, 32'h5, 0, 0, 0, 1, 12, 32'h1234, 32'h8000_0000);
    tbl[23] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   1, 1, 31, 32'h5, 32'h8000_0000);
    tbl[24] = mkv(0, 0, 0,            0, 0, 0, 0, 0,   0, 1, 31, 32'h5, 0);

    // power-on reset
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checkOutput("por.wen",     32'(wen),     0);
    checkOutput("por.wsel",    32'(wsel),    0);
    checkOutput("por.wdata",   wdata,        0);
    checkOutput("por.busy",    busy,         0);
    checkOutput("por.ld_full", 32'(ld_full), 0);
    repeat (3) @(posedge wclk);
    #1 rst_n = 1'b1;
    checkOutput("por.alu_ready", 32'(alu_ready), 1);
    checkOutput("por.ld_ready",  32'(ld_ready),  1);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i]);
      @(posedge wclk);
      #1;
      checkOutput($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      checkOutput($sformatf("v%0d.ld_ready", i),  32'(ld_ready),  32'(tbl[i].e_lr));
      checkOutput($sformatf("v%0d.wen", i),       32'(wen),       32'(tbl[i].e_wen));
      checkOutput($sformatf("v%0d.ld_full", i),   32'(ld_full),   0);
      checkOutput($sformatf("v%0d.busy", i),      busy,           tbl[i].e_busy);
      if (tbl[i].chk_w) begin
        checkOutput($sformatf("v%0d.wsel", i),  32'(wsel), 32'(tbl[i].e_wsel));
        checkOutput($sformatf("v%0d.wdata", i), wdata,     tbl[i].e_wdata);
      end
    end
    idle_inputs();
    repeat (2) @(posedge wclk);
    #1;

    // ALU and loads streaming together: FIFO fills, loads pre-empt, pointers wrap
    for (int n = 0; n < 3; n++) exp_q.push_back(alu_item(n));
    for (int n = 0; n < 3; n++) exp_q.push_back(ld_item(n));
    for (int n = 3; n < 10; n++) exp_q.push_back(alu_item(n));
    for (int n = 3; n < 6; n++) exp_q.push_back(ld_item(n));
    wr_log.delete();
    log_en = 1'b1;
    a_idx = 0;
    l_idx = 0;
    saw_full = 1'b0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (a_idx == 10 && l_idx == 6 && wr_log.size() >= 16) break;
      alu_valid = (a_idx < 10);
      alu_rd    = 5'(8 + a_idx);
      alu_data  = 32'hA000_0000 + 32'(a_idx);
      ld_valid  = (l_idx < 6);
      ld_rd     = 5'(20 + l_idx);
      ld_data   = 32'hB000_0000 + 32'(l_idx);
      @(negedge wclk);
      acc_a = alu_valid && alu_ready;
      acc_l = ld_valid && ld_ready;
      if (alu_valid && !alu_ready) saw_stall = 1'b1;
      if (ld_full) saw_full = 1'b1;
      @(posedge wclk);
      #1;
      if (acc_a) a_idx++;
      if (acc_l) l_idx++;
    end
    idle_inputs();
    repeat (3) @(posedge wclk);
    #1;
    log_en = 1'b0;
    checkOutput("t4.alu_accepted", 32'(a_idx), 10);
    checkOutput("t4.ld_accepted",  32'(l_idx), 6);
    checkOutput("t4.ld_full_seen", 32'(saw_full), 1);
    checkOutput("t4.alu_stall_seen", 32'(saw_stall), 1);
    checkOutput("t4.write_count", 32'(wr_log.size()), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < wr_log.size()) begin
        checkOutput($sformatf("t4.w%0d.wsel", k),  32'(wr_log[k][36:32]), 32'(exp_q[k][36:32]));
        checkOutput($sformatf("t4.w%0d.wdata", k), wr_log[k][31:0],      exp_q[k][31:0]);
      end
    end

    // reset in the middle of traffic with three loads queued
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h100 + 32'(c);
      ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'h200 + 32'(c);
      iss_valid = (c == 0); iss_rd = 5'd9;
      @(posedge wclk);
      #1;
    end
    idle_inputs();
    checkOutput("t1.pre.wen",   32'(wen), 1);
    checkOutput("t1.pre.wdata", wdata,    32'h101);
    checkOutput("t1.pre.busy",  busy,     32'h200);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1.rst.wen",     32'(wen),     0);
    checkOutput("t1.rst.wsel",    32'(wsel),    0);
    checkOutput("t1.rst.wdata",   wdata,        0);
    checkOutput("t1.rst.busy",    busy,         0);
    checkOutput("t1.rst.ld_full", 32'(ld_full), 0);
    @(posedge wclk);
    #1 rst_n = 1'b1;
    checkOutput("t1.rel.alu_ready", 32'(alu_ready), 1);
    checkOutput("t1.rel.ld_ready",  32'(ld_ready),  1);
    for (int c = 0; c < 5; c++) begin
      @(posedge wclk);
      #1;
      checkOutput($sformatf("t1.post%0d.wen", c),  32'(wen), 0);
      checkOutput($sformatf("t1.post%0d.busy", c), busy,     0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
